// File: rtl/sort4_pkg.sv
// sort4_pkg: shared encodings and sizes for the sequential four-element sorter.
`default_nettype none

package sort4_pkg;

    localparam int NUM_ELEM = 4;
    localparam int ELEM_W   = 4;
    localparam int DATA_W   = NUM_ELEM * ELEM_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CMP  = S_CMP,
        ST_DONE = S_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cmpr4.sv
// cmpr4: combinational 4-bit unsigned magnitude comparator.
`default_nettype none

module cmpr4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       alessb,
    output logic       aequalb,
    output logic       agreaterb
);

    assign alessb    = (a < b);
    assign aequalb   = (a == b);
    assign agreaterb = (a > b);

endmodule

`default_nettype wire

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: bubble-sorts four 4-bit elements, one shared-comparator compare per clock,
// with early exit when a pass makes no swap.
`default_nettype none

module sort4_ctrl
    import sort4_pkg::*;
#(
    parameter bit DESCEND = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    data_out,
    output logic [2:0]           swap_count
);

    state_t              state_q;
    logic [ELEM_W-1:0]   elem_q [NUM_ELEM];
    logic [ELEM_W-1:0]   elem_d [NUM_ELEM];
    logic [1:0]          pass_q;
    logic [1:0]          idx_q;
    logic                swapped_q;
    logic [2:0]          cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [2:0]          swap_count_q;

    logic [ELEM_W-1:0]   cmp_a_d;
    logic [ELEM_W-1:0]   cmp_b_d;
    logic                lt_d;
    logic                eq_d;
    logic                gt_d;
    logic                swap_d;
    logic                swapped_d;
    logic [2:0]          cnt_d;
    logic                last_idx_d;
    logic [DATA_W-1:0]   packed_d;

    assign cmp_a_d = elem_q[idx_q];
    assign cmp_b_d = elem_q[idx_q + 2'd1];

    cmpr4 u_cmp (
        .a         (cmp_a_d),
        .b         (cmp_b_d),
        .alessb    (lt_d),
        .aequalb   (eq_d),
        .agreaterb (gt_d)
    );

    // Equal neighbours never exchange, which keeps the sort stable.
    assign swap_d     = !eq_d && (DESCEND ? lt_d : gt_d);
    assign swapped_d  = swapped_q | swap_d;
    assign cnt_d      = cnt_q + {2'b00, swap_d};
    assign last_idx_d = (idx_q == (2'd2 - pass_q));

    always_comb begin
        elem_d = elem_q;
        if (swap_d) begin
            elem_d[idx_q]        = cmp_b_d;
            elem_d[idx_q + 2'd1] = cmp_a_d;
        end
        packed_d = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            packed_d[i*ELEM_W +: ELEM_W] = elem_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NUM_ELEM; i++) begin
                elem_q[i] <= '0;
            end
            pass_q       <= '0;
            idx_q        <= '0;
            swapped_q    <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            swap_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_ELEM; i++) begin
                            elem_q[i] <= data_in[i*ELEM_W +: ELEM_W];
                        end
                        pass_q    <= '0;
                        idx_q     <= '0;
                        swapped_q <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    elem_q <= elem_d;
                    cnt_q  <= cnt_d;
                    if (last_idx_d) begin
                        // A clean pass means the list is ordered; pass 2 is the final one anyway.
                        if (!swapped_d || (pass_q == 2'd2)) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            data_out_q   <= packed_d;
                            swap_count_q <= cnt_d;
                        end else begin
                            pass_q    <= pass_q + 2'd1;
                            idx_q     <= '0;
                            swapped_q <= 1'b0;
                        end
                    end else begin
                        idx_q     <= idx_q + 2'd1;
                        swapped_q <= swapped_d;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_out_q;
    assign swap_count = swap_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
// tb_sort4_ctrl: random and directed sorts of both sort orders against a plain bubble-sort model.
`default_nettype none

module tb_sort4_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        busy_a, done_a, busy_d, done_d;
    logic [15:0] out_a, out_d;
    logic [2:0]  sc_a, sc_d;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          first_done;
        int          pulses;
        int          busy_low;
        logic [15:0] res;
        logic [2:0]  sc;
    } obs_t;

    always #5 clk = ~clk;

    sort4_ctrl #(.DESCEND(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy_a), .done(done_a), .data_out(out_a), .swap_count(sc_a)
    );

    sort4_ctrl #(.DESCEND(1'b1)) dut_d (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy_d), .done(done_d), .data_out(out_d), .swap_count(sc_d)
    );

    // Reference: textbook bubble sort with early exit, counting compares and swaps.
    task automatic model(input logic [15:0] d, input bit desc,
                         output logic [15:0] o, output int sw, output int n);
        int e[4];
        int t;
        bit sp;
        for (int i = 0; i < 4; i++) e[i] = int'(d[i*4 +: 4]);
        sw = 0;
        n  = 0;
        for (int p = 0; p < 3; p++) begin
            sp = 0;
            for (int i = 0; i < 3 - p; i++) begin
                n++;
                if (desc ? (e[i] < e[i+1]) : (e[i] > e[i+1])) begin
                    t = e[i]; e[i] = e[i+1]; e[i+1] = t;
                    sw++;
                    sp = 1;
                end
            end
            if (!sp) break;
        end
        o = '0;
        for (int i = 0; i < 4; i++) o[i*4 +: 4] = e[i][3:0];
    endtask

    // Pulses start for one accepting edge, then scrambles data_in; returns at the negedge after it.
    task automatic kick(input logic [15:0] d);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'($urandom);
    endtask

    // Samples both DUTs once per cycle (c=0 is the cycle after the accepting edge).
    task automatic observe(input int ncyc, input int inj_c, input logic [15:0] inj_d,
                           output obs_t oa, output obs_t od);
        oa.first_done = -1; oa.pulses = 0; oa.busy_low = -1;
        od.first_done = -1; od.pulses = 0; od.busy_low = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (c == inj_c) begin
                start   = 1'b1;
                data_in = inj_d;
            end else if (c == inj_c + 1) begin
                start   = 1'b0;
            end
            if (done_a) begin
                oa.pulses++;
                if (oa.first_done < 0) oa.first_done = c;
            end
            if (done_d) begin
                od.pulses++;
                if (od.first_done < 0) od.first_done = c;
            end
            if (!busy_a && oa.busy_low < 0) oa.busy_low = c;
            if (!busy_d && od.busy_low < 0) od.busy_low = c;
        end
        oa.res = out_a; oa.sc = sc_a;
        od.res = out_d; od.sc = sc_d;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_in = 16'hFFFF;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got %b exp 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done_a got %b exp 0", done_a); end
        checks++; if (out_a !== 16'h0) begin failures++; $display("FAIL reset_out_a got %h exp 0000", out_a); end
        checks++; if (sc_a !== 3'd0) begin failures++; $display("FAIL reset_sc_a got %0d exp 0", sc_a); end
        checks++; if (busy_d !== 1'b0) begin failures++; $display("FAIL reset_busy_d got %b exp 0", busy_d); end
        checks++; if (done_d !== 1'b0) begin failures++; $display("FAIL reset_done_d got %b exp 0", done_d); end
        checks++; if (out_d !== 16'h0) begin failures++; $display("FAIL reset_out_d got %h exp 0000", out_d); end
        checks++; if (sc_d !== 3'd0) begin failures++; $display("FAIL reset_sc_d got %0d exp 0", sc_d); end
        rst = 1'b0;
    endtask

    task automatic test_sorting();
        logic [15:0] vec [$];
        logic [15:0] ea, ed;
        int sa, sd, na, nd;
        obs_t oa, od;
        vec = '{16'h1234, 16'h4321, 16'h7777, 16'h2121, 16'hF00F};
        for (int i = 0; i < 16; i++) vec.push_back(16'($urandom));
        foreach (vec[v]) begin
            model(vec[v], 1'b0, ea, sa, na);
            model(vec[v], 1'b1, ed, sd, nd);
            kick(vec[v]);
            observe(10, -1, 16'h0, oa, od);
            checks++; if (oa.first_done !== na) begin failures++; $display("FAIL sort_latency_a in=%h got %0d exp %0d", vec[v], oa.first_done, na); end
            checks++; if (oa.pulses !== 1) begin failures++; $display("FAIL sort_pulses_a in=%h got %0d exp 1", vec[v], oa.pulses); end
            checks++; if (oa.busy_low !== na + 1) begin failures++; $display("FAIL sort_busy_a in=%h low_at=%0d exp %0d", vec[v], oa.busy_low, na + 1); end
            checks++; if (oa.res !== ea) begin failures++; $display("FAIL sort_data_a in=%h got %h exp %h", vec[v], oa.res, ea); end
            checks++; if (oa.sc !== 3'(sa)) begin failures++; $display("FAIL sort_swaps_a in=%h got %0d exp %0d", vec[v], oa.sc, sa); end
            checks++; if (od.first_done !== nd) begin failures++; $display("FAIL sort_latency_d in=%h got %0d exp %0d", vec[v], od.first_done, nd); end
            checks++; if (od.pulses !== 1) begin failures++; $display("FAIL sort_pulses_d in=%h got %0d exp 1", vec[v], od.pulses); end
            checks++; if (od.busy_low !== nd + 1) begin failures++; $display("FAIL sort_busy_d in=%h low_at=%0d exp %0d", vec[v], od.busy_low, nd + 1); end
            checks++; if (od.res !== ed) begin failures++; $display("FAIL sort_data_d in=%h got %h exp %h", vec[v], od.res, ed); end
            checks++; if (od.sc !== 3'(sd)) begin failures++; $display("FAIL sort_swaps_d in=%h got %0d exp %0d", vec[v], od.sc, sd); end
        end
    endtask

    task automatic test_busy_start();
        logic [15:0] ea, ed;
        int sa, sd, na, nd;
        obs_t oa, od;
        model(16'h1234, 1'b0, ea, sa, na);
        model(16'h1234, 1'b1, ed, sd, nd);
        kick(16'h1234);
        observe(12, 2, 16'h9C5A, oa, od);
        checks++; if (oa.pulses !== 1) begin failures++; $display("FAIL busy_start_pulses_a got %0d exp 1", oa.pulses); end
        checks++; if (oa.res !== ea) begin failures++; $display("FAIL busy_start_data_a got %h exp %h", oa.res, ea); end
        checks++; if (oa.sc !== 3'(sa)) begin failures++; $display("FAIL busy_start_swaps_a got %0d exp %0d", oa.sc, sa); end
        checks++; if (od.pulses !== 1) begin failures++; $display("FAIL busy_start_pulses_d got %0d exp 1", od.pulses); end
        checks++; if (od.res !== ed) begin failures++; $display("FAIL busy_start_data_d got %h exp %h", od.res, ed); end
        checks++; if (od.sc !== 3'(sd)) begin failures++; $display("FAIL busy_start_swaps_d got %0d exp %0d", od.sc, sd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea, ed;
        int sa, sd, na, nd;
        bit xa, xd;
        model(16'h1234, 1'b0, ea, sa, na);
        model(16'h1234, 1'b1, ed, sd, nd);
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'h1234;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            xa = (c >= na) && (((c - na) % (na + 2)) == 0);
            xd = (c >= nd) && (((c - nd) % (nd + 2)) == 0);
            checks++; if (done_a !== xa) begin failures++; $display("FAIL b2b_done_a cycle=%0d got %b exp %b", c, done_a, xa); end
            checks++; if (done_d !== xd) begin failures++; $display("FAIL b2b_done_d cycle=%0d got %b exp %b", c, done_d, xd); end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_a !== ea) begin failures++; $display("FAIL b2b_data_a got %h exp %h", out_a, ea); end
        checks++; if (out_d !== ed) begin failures++; $display("FAIL b2b_data_d got %h exp %h", out_d, ed); end
        repeat (12) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] ea, ed;
        int sa, sd, na, nd;
        obs_t oa, od;
        kick(16'h1234);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_busy_a got %b exp 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL midrst_done_a got %b exp 0", done_a); end
        checks++; if (out_a !== 16'h0) begin failures++; $display("FAIL midrst_out_a got %h exp 0000", out_a); end
        checks++; if (sc_a !== 3'd0) begin failures++; $display("FAIL midrst_sc_a got %0d exp 0", sc_a); end
        checks++; if (done_d !== 1'b0) begin failures++; $display("FAIL midrst_done_d got %b exp 0", done_d); end
        checks++; if (out_d !== 16'h0) begin failures++; $display("FAIL midrst_out_d got %h exp 0000", out_d); end
        model(16'hA5C3, 1'b0, ea, sa, na);
        model(16'hA5C3, 1'b1, ed, sd, nd);
        kick(16'hA5C3);
        observe(10, -1, 16'h0, oa, od);
        checks++; if (oa.res !== ea) begin failures++; $display("FAIL midrst_resort_a got %h exp %h", oa.res, ea); end
        checks++; if (oa.sc !== 3'(sa)) begin failures++; $display("FAIL midrst_resort_sc_a got %0d exp %0d", oa.sc, sa); end
        checks++; if (od.res !== ed) begin failures++; $display("FAIL midrst_resort_d got %h exp %h", od.res, ed); end
        checks++; if (oa.first_done !== na) begin failures++; $display("FAIL midrst_latency_a got %0d exp %0d", oa.first_done, na); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = 16'h0;
        test_reset();
        test_sorting();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
